regfile_mp_sb: RTL

- Parametrised multi-port register file for the multi-cycle and pipelined cores.
- Generalised in data width and depth.
- Two read ports and two write ports, with write-port priority.
- Hardwired zero register.
- Per-register pending-write scoreboard for hazard detection.
- Sequential clear engine that sweeps the array to zero on request, without a global reset.

---
 rtl/regfile_mp_sb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Two-read / two-write register file with a per-register pending-write
//   scoreboard and a sequential clear engine that zeroes the array one
//   register per cycle without using the global reset.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ra1/ra2              read addresses
//   rd1/rd2              combinational read data
//   pend1/pend2          combinational scoreboard bits for ra1/ra2
//   we1/wa1/wd1          write port 1
//   we2/wa2/wd2          write port 2 (wins over port 1 on the same address)
//   sb_set/sb_addr       mark a register as awaiting writeback
//   clr_req              start a clear sweep (only taken in IDLE)
//   clr_busy             sweep in progress
//   wr_drop              one-cycle pulse: a write/sb_set arrived during a sweep
//
// Build option
//   REGFILE_BYPASS_EN    forward same-cycle writes to the read ports (IDLE only)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | normal operation: writes and scoreboard updates accepted
// SWEEP | clearing reg[r_idx] each cycle; writes/sb_set are dropped
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              pend1,
    output logic              pend2,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic               r_busy;
    logic               r_drop;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]   r_pend;

    logic               w_wr1_ok;
    logic               w_wr2_ok;
    logic               w_sb_ok;

    // Writes to the hardwired zero register are suppressed at the source so
    // that neither the array nor the scoreboard ever change for address 0.
    assign w_wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign w_wr2_ok = we2 && !((ZERO_REG != 0) && (wa2 == '0));
    assign w_sb_ok  = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
            r_pend  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Port 2 is applied after port 1 so it wins on a collision.
                    if (w_wr1_ok) begin
                        r_mem[wa1]  <= wd1;
                        r_pend[wa1] <= 1'b0;
                    end
                    if (w_wr2_ok) begin
                        r_mem[wa2]  <= wd2;
                        r_pend[wa2] <= 1'b0;
                    end
                    // A new issue supersedes a writeback landing in the same cycle.
                    if (w_sb_ok) begin
                        r_pend[sb_addr] <= 1'b1;
                    end
                    if (clr_req) begin
                        r_state <= SWEEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    r_mem[r_idx]  <= '0;
                    r_pend[r_idx] <= 1'b0;
                    r_idx         <= r_idx + 1'b1;
                    r_drop        <= we1 || we2 || sb_set;
                    if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_pend1;
    logic              w_pend2;

    always_comb begin
        w_rd1   = r_mem[ra1];
        w_rd2   = r_mem[ra2];
        w_pend1 = r_pend[ra1];
        w_pend2 = r_pend[ra2];
`ifdef REGFILE_BYPASS_EN
        if (r_state == IDLE) begin
            if (we2 && (wa2 == ra1))      w_rd1 = wd2;
            else if (we1 && (wa1 == ra1)) w_rd1 = wd1;
            if (we2 && (wa2 == ra2))      w_rd2 = wd2;
            else if (we1 && (wa1 == ra2)) w_rd2 = wd1;
            // A landing write retires the pending mark unless it is re-issued now.
            if ((we1 && (wa1 == ra1)) || (we2 && (wa2 == ra1)))
                w_pend1 = sb_set && (sb_addr == ra1);
            if ((we1 && (wa1 == ra2)) || (we2 && (wa2 == ra2)))
                w_pend2 = sb_set && (sb_addr == ra2);
        end
`endif
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            w_rd1   = '0;
            w_pend1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (ra2 == '0)) begin
            w_rd2   = '0;
            w_pend2 = 1'b0;
        end
    end

    assign rd1      = w_rd1;
    assign rd2      = w_rd2;
    assign pend1    = w_pend1;
    assign pend2    = w_pend2;
    assign clr_busy = r_busy;
    assign wr_drop  = r_drop;

endmodule
